// File: rtl/input_conditioner.sv
// Two-channel push-button front end: 2-FF synchroniser, stable-count debounce
// and rising-edge pulse per channel, with fully registered outputs.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic inputClk,
   input  logic inputReset,
   input  logic inputRawI,
   input  logic inputRawS,
   output logic outputI,
   output logic outputS,
   output logic outputLevelI,
   output logic outputLevelS
);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      IDLE_HIGH,
      WAIT_LOW
   } stateType;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0] rawVec;
   assign rawVec = {inputRawS, inputRawI};

   // Channel 0 is I, channel 1 is S; the two share nothing but the clock and reset.
   for (genvar ch = 0; ch < 2; ch++) begin : gChannel
      logic             syncMeta;
      logic             syncOut;
      stateType         state;
      stateType         nextState;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] nextCnt;
      logic             level;
      logic             nextLevel;
      logic             pulse;
      logic             nextPulse;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of the others, matching real flip-flops.
      always_ff @(posedge inputClk) begin
         if (!inputReset) begin
            syncMeta <= 1'b0;
            syncOut  <= 1'b0;
            state    <= IDLE_LOW;
            cnt      <= '0;
            level    <= 1'b0;
            pulse    <= 1'b0;
         end else begin
            syncMeta <= rawVec[ch];
            syncOut  <= syncMeta;
            state    <= nextState;
            cnt      <= nextCnt;
            level    <= nextLevel;
            pulse    <= nextPulse;
         end
      end

      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      always_comb begin
         nextState = state;
         unique case (state)
            IDLE_LOW:  if (syncOut) nextState = WAIT_HIGH;
            WAIT_HIGH: begin
               if (!syncOut)            nextState = IDLE_LOW;
               else if (cnt == CNT_MAX) nextState = IDLE_HIGH;
            end
            IDLE_HIGH: if (!syncOut) nextState = WAIT_LOW;
            WAIT_LOW: begin
               if (syncOut)             nextState = IDLE_HIGH;
               else if (cnt == CNT_MAX) nextState = IDLE_LOW;
            end
            default:   nextState = IDLE_LOW;
         endcase
      end

      // Counter stops at CNT_MAX because reaching it always leaves the wait state.
      always_comb begin
         nextCnt   = '0;
         nextLevel = level;
         nextPulse = 1'b0;
         unique case (state)
            IDLE_LOW:  if (syncOut) nextCnt = CNT_ONE;
            WAIT_HIGH: begin
               if (syncOut) begin
                  if (cnt == CNT_MAX) begin
                     nextLevel = 1'b1;
                     nextPulse = 1'b1;
                  end else begin
                     nextCnt = cnt + CNT_ONE;
                  end
               end
            end
            IDLE_HIGH: if (!syncOut) nextCnt = CNT_ONE;
            WAIT_LOW: begin
               if (!syncOut) begin
                  if (cnt == CNT_MAX) nextLevel = 1'b0;
                  else                nextCnt   = cnt + CNT_ONE;
               end
            end
            default: begin
               nextCnt   = '0;
               nextLevel = 1'b0;
            end
         endcase
      end
   end

   assign outputI      = gChannel[0].pulse;
   assign outputS      = gChannel[1].pulse;
   assign outputLevelI = gChannel[0].level;
   assign outputLevelS = gChannel[1].level;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with D=4: reset, press, release,
// bounce rejection, simultaneous channels and reset in mid-debounce.
module tb_input_conditioner;

   logic inputClk;
   logic inputReset;
   logic inputRawI;
   logic inputRawS;
   logic outputI;
   logic outputS;
   logic outputLevelI;
   logic outputLevelS;

   int checks;
   int failures;

   input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(16)
   ) dut (
      .inputClk    (inputClk),
      .inputReset  (inputReset),
      .inputRawI   (inputRawI),
      .inputRawS   (inputRawS),
      .outputI     (outputI),
      .outputS     (outputS),
      .outputLevelI(outputLevelI),
      .outputLevelS(outputLevelS)
   );

   initial inputClk = 1'b0;
   always #5 inputClk = ~inputClk;

   // Advance one rising edge and settle; inputs set after this are sampled next edge.
   task automatic step();
      @(posedge inputClk);
      #1;
   endtask

   task automatic test_reset();
      inputReset = 1'b0;
      for (int e = 0; e < 2; e++) begin
         inputRawI = e[0];
         inputRawS = ~e[0];
         step();
         if ({outputI, outputS, outputLevelI, outputLevelS} !== 4'b0000) begin
            $display("FAIL reset_outputs edge=%0d got=%b want=0000", e,
                     {outputI, outputS, outputLevelI, outputLevelS});
            failures++;
         end
         checks++;
      end
      inputRawI  = 1'b0;
      inputRawS  = 1'b0;
      inputReset = 1'b1;
      for (int e = 0; e < 4; e++) step();
      if ({outputI, outputS, outputLevelI, outputLevelS} !== 4'b0000) begin
         $display("FAIL reset_idle got=%b want=0000",
                  {outputI, outputS, outputLevelI, outputLevelS});
         failures++;
      end
      checks++;
   endtask

   task automatic test_clean_press();
      inputRawI = 1'b1;
      for (int e = 0; e < 20; e++) begin
         step();
         if (outputI !== (e == 6)) begin
            $display("FAIL press_pulse edge=k+%0d got=%b want=%b", e, outputI, (e == 6));
            failures++;
         end
         checks++;
         if (outputLevelI !== (e >= 6)) begin
            $display("FAIL press_level edge=k+%0d got=%b want=%b", e, outputLevelI, (e >= 6));
            failures++;
         end
         checks++;
         if (outputS !== 1'b0 || outputLevelS !== 1'b0) begin
            $display("FAIL press_s_quiet edge=k+%0d got=%b%b want=00", e, outputS, outputLevelS);
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_release();
      inputRawI = 1'b0;
      for (int e = 0; e < 12; e++) begin
         step();
         if (outputLevelI !== (e < 6)) begin
            $display("FAIL release_level edge=m+%0d got=%b want=%b", e, outputLevelI, (e < 6));
            failures++;
         end
         checks++;
         if (outputI !== 1'b0) begin
            $display("FAIL release_pulse edge=m+%0d got=%b want=0", e, outputI);
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_bounce();
      logic [5:0] pattern;
      pattern = 6'b110111;  // applied LSB first: high 3, low 1, high 2
      for (int e = 0; e < 20; e++) begin
         inputRawI = (e < 6) ? pattern[e] : 1'b0;
         step();
         if (outputI !== 1'b0 || outputLevelI !== 1'b0) begin
            $display("FAIL bounce edge=%0d got=%b%b want=00", e, outputI, outputLevelI);
            failures++;
         end
         checks++;
      end
   endtask

   task automatic test_simultaneous();
      int pulsesI;
      int pulsesS;
      pulsesI   = 0;
      pulsesS   = 0;
      inputRawI = 1'b1;
      inputRawS = 1'b1;
      for (int e = 0; e < 14; e++) begin
         step();
         if (outputI === 1'b1) pulsesI++;
         if (outputS === 1'b1) pulsesS++;
         if (outputI !== (e == 6) || outputS !== (e == 6)) begin
            $display("FAIL simul_pulse edge=k+%0d got=%b%b want=%b%b", e, outputI, outputS,
                     (e == 6), (e == 6));
            failures++;
         end
         checks++;
      end
      if (pulsesI !== 1 || pulsesS !== 1) begin
         $display("FAIL simul_count got=%0d,%0d want=1,1", pulsesI, pulsesS);
         failures++;
      end
      checks++;
      inputRawI = 1'b0;
      inputRawS = 1'b0;
      for (int e = 0; e < 8; e++) step();
      if (outputLevelI !== 1'b0 || outputLevelS !== 1'b0) begin
         $display("FAIL simul_release got=%b%b want=00", outputLevelI, outputLevelS);
         failures++;
      end
      checks++;
   endtask

   task automatic test_reset_mid_op();
      inputRawI = 1'b1;
      for (int e = 0; e < 20; e++) begin
         inputReset = (e == 4) ? 1'b0 : 1'b1;
         step();
         if (outputI !== (e == 11)) begin
            $display("FAIL midrst_pulse edge=k+%0d got=%b want=%b", e, outputI, (e == 11));
            failures++;
         end
         checks++;
         if (outputLevelI !== (e >= 11)) begin
            $display("FAIL midrst_level edge=k+%0d got=%b want=%b", e, outputLevelI, (e >= 11));
            failures++;
         end
         checks++;
      end
      inputReset = 1'b1;
      inputRawI  = 1'b0;
      for (int e = 0; e < 8; e++) step();
      if (outputS !== 1'b0 || outputLevelS !== 1'b0) begin
         $display("FAIL midrst_s_quiet got=%b%b want=00", outputS, outputLevelS);
         failures++;
      end
      checks++;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      inputReset = 1'b0;
      inputRawI  = 1'b0;
      inputRawS  = 1'b0;
      #1;
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
